// File: rtl/seq_roll_left.sv
// Multi-cycle left rotate / rotate-through-carry / shift-left unit.
// Works iteratively on a latched operand, then publishes result plus
// carry/zero/negitive flags on the edge that enters DONE.
//
// state  | meaning
// -------+----------------------------------------------------------
// S_IDLE | waiting for start; outputs hold the last result
// S_RUN  | stepping the working value until remaining count is 0
// S_DONE | one-cycle done pulse, then back to S_IDLE

package seq_roll_left_pkg;
  typedef logic [63:0] ulong_t;
  typedef logic [7:0]  ubyte_t;
  typedef logic [3:0]  sizeFlags_t;

  // One-hot width flags; any other pattern is an invalid size.
  localparam sizeFlags_t BITS_8  = 4'b0001;
  localparam sizeFlags_t BITS_16 = 4'b0010;
  localparam sizeFlags_t BITS_32 = 4'b0100;
  localparam sizeFlags_t BITS_64 = 4'b1000;
endpackage

module seq_roll_left
  import seq_roll_left_pkg::*;
#(
  parameter bit FAST_STEP = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       mode,
  input  sizeFlags_t size,
  input  logic       useCarry,
  input  logic       carryIn,
  input  ulong_t     a,
  input  ubyte_t     b,
  output logic       busy,
  output logic       done,
  output ulong_t     result,
  output logic       carry,
  output logic       zero,
  output logic       negitive
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  function automatic logic [6:0] width_of(input sizeFlags_t s);
    case (s)
      BITS_8:  return 7'd8;
      BITS_16: return 7'd16;
      BITS_32: return 7'd32;
      BITS_64: return 7'd64;
      default: return 7'd0;
    endcase
  endfunction

  function automatic ulong_t mask_of(input logic [6:0] n);
    ulong_t m;
    m = '0;
    for (int i = 0; i < 64; i++) begin
      if (i < int'(n)) m[i] = 1'b1;
    end
    return m;
  endfunction

  // Rotate the low n bits of v left by s (s <= n).
  function automatic ulong_t rotl_n(input ulong_t v, input logic [6:0] n, input logic [3:0] s);
    ulong_t     m;
    ulong_t     vm;
    logic [6:0] back;
    m    = mask_of(n);
    vm   = v & m;
    back = n - {3'b000, s};
    return ((vm << s) | (vm >> back)) & m;
  endfunction

  // Rotate the (n+1)-bit ring {c, v[n-1:0]} left by s; carry sits at bit n.
  function automatic logic [64:0] rotc_n(input ulong_t v, input logic c,
                                         input logic [6:0] n, input logic [3:0] s);
    logic [64:0] m1;
    logic [64:0] ring;
    logic [6:0]  back;
    m1       = {1'b0, mask_of(n)};
    m1[n]    = 1'b1;
    ring     = {1'b0, v & mask_of(n)};
    ring[n]  = c;
    back     = n + 7'd1 - {3'b000, s};
    return ((ring << s) | (ring >> back)) & m1;
  endfunction

  state_t     state_q;
  sizeFlags_t size_q;
  logic       mode_q, uc_q;
  ulong_t     v_q, v_d;
  logic       c_q, c_d;
  logic [7:0] rem_q, rem_d;
  logic       busy_q, done_q, carry_q, zero_q, neg_q;
  ulong_t     result_q;

  logic [6:0]  n_acc;
  ulong_t      a_m;
  logic [7:0]  k_acc, kr, kc, ks;
  logic        c_acc;

  // Operand capture and step count for the accept edge.
  always_comb begin
    n_acc = width_of(size);
    a_m   = a & mask_of(n_acc);
    kr    = '0;
    kc    = '0;
    ks    = '0;
    case (size)
      BITS_8: begin
        kr = b % 8'd8;
        kc = b % 8'd9;
        ks = (b > 8'd9) ? 8'd9 : b;
      end
      BITS_16: begin
        kr = b % 8'd16;
        kc = b % 8'd17;
        ks = (b > 8'd17) ? 8'd17 : b;
      end
      BITS_32: begin
        kr = b % 8'd32;
        kc = b % 8'd33;
        ks = (b > 8'd33) ? 8'd33 : b;
      end
      BITS_64: begin
        kr = b % 8'd64;
        kc = b % 8'd65;
        ks = (b > 8'd65) ? 8'd65 : b;
      end
      default: ;
    endcase
    k_acc = mode ? ks : (useCarry ? kc : kr);
    c_acc = (n_acc != 7'd0) ? carryIn : 1'b0;
  end

  logic [6:0]  n_run;
  ulong_t      m_run;
  logic [3:0]  step;
  logic [5:0]  out_idx;
  logic [64:0] ring_d;

  // One RUN step: advance 8 positions when allowed, otherwise 1.
  always_comb begin
    n_run   = width_of(size_q);
    m_run   = mask_of(n_run);
    step    = (FAST_STEP && (rem_q >= 8'd8)) ? 4'd8 : 4'd1;
    rem_d   = rem_q - {4'b0000, step};
    out_idx = 6'(n_run - {3'b000, step});
    ring_d  = rotc_n(v_q, c_q, n_run, step);
    v_d     = v_q;
    c_d     = c_q;
    if (mode_q) begin
      c_d = v_q[out_idx];
      v_d = (v_q << step) & m_run;
    end else if (uc_q) begin
      v_d = ring_d[63:0] & m_run;
      c_d = ring_d[n_run];
    end else begin
      v_d = rotl_n(v_q, n_run, step);
    end
  end

  ulong_t     src_v;
  logic       src_c, src_mode, src_uc, src_kz;
  logic [6:0] src_n;
  logic [5:0] neg_idx;
  logic       car_d, zero_d, neg_d;

  // Flags for the edge entering DONE, from either the accept path (k == 0) or the final step.
  always_comb begin
    if (state_q == S_IDLE) begin
      src_v    = a_m;
      src_c    = c_acc;
      src_mode = mode;
      src_uc   = useCarry;
      src_kz   = 1'b1;
      src_n    = n_acc;
    end else begin
      src_v    = v_d;
      src_c    = c_d;
      src_mode = mode_q;
      src_uc   = uc_q;
      src_kz   = 1'b0;
      src_n    = n_run;
    end
    if (src_mode)    car_d = src_kz ? 1'b0 : src_c;
    else if (src_uc) car_d = src_c;
    else             car_d = src_kz ? 1'b0 : src_v[0];
    neg_idx = 6'(src_n - 7'd1);
    neg_d   = (src_n != 7'd0) && src_v[neg_idx];
    zero_d  = (src_v == '0);
  end

  // Sequencer with registered handshake and result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      size_q   <= '0;
      mode_q   <= 1'b0;
      uc_q     <= 1'b0;
      v_q      <= '0;
      c_q      <= 1'b0;
      rem_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
      neg_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            size_q <= size;
            mode_q <= mode;
            uc_q   <= useCarry;
            v_q    <= a_m;
            c_q    <= c_acc;
            rem_q  <= k_acc;
            busy_q <= 1'b1;
            if (k_acc == 8'd0) begin
              state_q  <= S_DONE;
              done_q   <= 1'b1;
              result_q <= src_v;
              carry_q  <= car_d;
              zero_q   <= zero_d;
              neg_q    <= neg_d;
            end else begin
              state_q <= S_RUN;
            end
          end
        end
        S_RUN: begin
          v_q   <= v_d;
          c_q   <= c_d;
          rem_q <= rem_d;
          if (rem_d == 8'd0) begin
            state_q  <= S_DONE;
            done_q   <= 1'b1;
            result_q <= src_v;
            carry_q  <= car_d;
            zero_q   <= zero_d;
            neg_q    <= neg_d;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign result   = result_q;
  assign carry    = carry_q;
  assign zero     = zero_q;
  assign negitive = neg_q;

endmodule

// File: tb/tb_seq_roll_left.sv
// Directed bench for seq_roll_left: one fast-step and one single-step instance
// driven with the same stimulus, outputs compared to hand-computed values.
module tb_seq_roll_left;
  import seq_roll_left_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       mode = 1'b0;
  logic       useCarry = 1'b0;
  logic       carryIn = 1'b0;
  sizeFlags_t size = BITS_8;
  ulong_t     a = '0;
  ubyte_t     b = '0;

  logic   busy_f, done_f, car_o_f, zer_o_f, neg_o_f;
  ulong_t res_o_f;
  logic   busy_s, done_s, car_o_s, zer_o_s, neg_o_s;
  ulong_t res_o_s;

  seq_roll_left #(.FAST_STEP(1'b1)) dut_f (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .size(size),
    .useCarry(useCarry), .carryIn(carryIn), .a(a), .b(b),
    .busy(busy_f), .done(done_f), .result(res_o_f), .carry(car_o_f),
    .zero(zer_o_f), .negitive(neg_o_f)
  );

  seq_roll_left #(.FAST_STEP(1'b0)) dut_s (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .size(size),
    .useCarry(useCarry), .carryIn(carryIn), .a(a), .b(b),
    .busy(busy_s), .done(done_s), .result(res_o_s), .carry(car_o_s),
    .zero(zer_o_s), .negitive(neg_o_s)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;

  int     lat_f, lat_s;
  ulong_t res_f, res_s;
  logic   car_f, zer_f, neg_f, car_s, zer_s, neg_s;

  task automatic run_op(input sizeFlags_t s_i, input logic md, input logic uc, input logic ci,
                        input ulong_t av, input ubyte_t bv, input bit pulse_mid);
    @(negedge clk);
    size = s_i; mode = md; useCarry = uc; carryIn = ci; a = av; b = bv; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = ~av; b = bv + 8'd3; carryIn = ~ci;
    lat_f = -1; lat_s = -1;
    for (int cyc = 0; cyc < 150; cyc++) begin
      if (pulse_mid && cyc == 3) start = 1'b1;
      if (pulse_mid && cyc == 4) start = 1'b0;
      if (done_f && lat_f < 0) begin
        lat_f = cyc; res_f = res_o_f; car_f = car_o_f; zer_f = zer_o_f; neg_f = neg_o_f;
      end
      if (done_s && lat_s < 0) begin
        lat_s = cyc; res_s = res_o_s; car_s = car_o_s; zer_s = zer_o_s; neg_s = neg_o_s;
      end
      if (lat_f >= 0 && lat_s >= 0) break;
      @(posedge clk); #1;
    end
    start = 1'b0;
    if (lat_f < 0 || lat_s < 0) begin
      compared++; mismatched++;
      $display("FAIL op_timeout: lat_f=%0d lat_s=%0d, required both done within 150 cycles", lat_f, lat_s);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #1;
    @(posedge clk); @(posedge clk); #1;
    compared++;
    if ({busy_f, done_f, res_o_f, car_o_f, zer_o_f, neg_o_f} !== 69'd0) begin
      mismatched++;
      $display("FAIL reset_fast: got busy=%b done=%b res=%h c=%b z=%b n=%b, required all 0",
               busy_f, done_f, res_o_f, car_o_f, zer_o_f, neg_o_f);
    end
    compared++;
    if ({busy_s, done_s, res_o_s, car_o_s, zer_o_s, neg_o_s} !== 69'd0) begin
      mismatched++;
      $display("FAIL reset_slow: got busy=%b done=%b res=%h c=%b z=%b n=%b, required all 0",
               busy_s, done_s, res_o_s, car_o_s, zer_o_s, neg_o_s);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_rotate();
    run_op(BITS_8, 1'b0, 1'b0, 1'b0, 64'h81, 8'd1, 1'b0);
    compared++;
    if ({lat_f, lat_s} !== {32'sd1, 32'sd1} || {res_f, car_f, zer_f, neg_f} !== {64'h03, 3'b100}) begin
      mismatched++;
      $display("FAIL rot8_by1: lat=%0d/%0d res=%h c=%b z=%b n=%b, required lat=1/1 res=03 c=1 z=0 n=0",
               lat_f, lat_s, res_f, car_f, zer_f, neg_f);
    end
    run_op(BITS_16, 1'b0, 1'b0, 1'b1, 64'h1234, 8'd12, 1'b0);
    compared++;
    if ({lat_f, lat_s} !== {32'sd5, 32'sd12} || {res_f, car_f, zer_f, neg_f} !== {64'h4123, 3'b100}
        || res_s !== 64'h4123) begin
      mismatched++;
      $display("FAIL rot16_by12: lat=%0d/%0d res=%h/%h c=%b z=%b n=%b, required lat=5/12 res=4123 c=1 z=0 n=0",
               lat_f, lat_s, res_f, res_s, car_f, zer_f, neg_f);
    end
    run_op(BITS_32, 1'b0, 1'b0, 1'b0, 64'hFFFF_FFFF_0000_0001, 8'd1, 1'b0);
    compared++;
    if ({res_f, car_f, zer_f, neg_f} !== {64'h2, 3'b000} || lat_f !== 1) begin
      mismatched++;
      $display("FAIL rot32_mask: lat=%0d res=%h c=%b z=%b n=%b, required lat=1 res=2 c=0 z=0 n=0",
               lat_f, res_f, car_f, zer_f, neg_f);
    end
  endtask

  task automatic test_rotate_carry();
    run_op(BITS_8, 1'b0, 1'b1, 1'b0, 64'h80, 8'd1, 1'b0);
    compared++;
    if ({res_f, car_f, zer_f, neg_f} !== {64'h00, 3'b110} || lat_f !== 1) begin
      mismatched++;
      $display("FAIL rotc8_by1: lat=%0d res=%h c=%b z=%b n=%b, required lat=1 res=00 c=1 z=1 n=0",
               lat_f, res_f, car_f, zer_f, neg_f);
    end
    run_op(BITS_8, 1'b0, 1'b1, 1'b0, 64'h80, 8'd9, 1'b0);
    compared++;
    if ({lat_f, lat_s} !== {32'sd0, 32'sd0} || {res_f, car_f, zer_f, neg_f} !== {64'h80, 3'b001}) begin
      mismatched++;
      $display("FAIL rotc8_k0: lat=%0d/%0d res=%h c=%b z=%b n=%b, required lat=0/0 res=80 c=0 z=0 n=1",
               lat_f, lat_s, res_f, car_f, zer_f, neg_f);
    end
    run_op(BITS_8, 1'b0, 1'b1, 1'b1, 64'h01, 8'd3, 1'b0);
    compared++;
    if ({res_f, car_f, zer_f, neg_f} !== {64'h0C, 3'b000} || lat_f !== 3) begin
      mismatched++;
      $display("FAIL rotc8_by3: lat=%0d res=%h c=%b z=%b n=%b, required lat=3 res=0C c=0 z=0 n=0",
               lat_f, res_f, car_f, zer_f, neg_f);
    end
    run_op(BITS_8, 1'b0, 1'b1, 1'b0, 64'h01, 8'd8, 1'b0);
    compared++;
    if ({lat_f, lat_s} !== {32'sd1, 32'sd8} || {res_f, car_f, zer_f} !== {64'h0, 2'b11}
        || {res_s, car_s} !== {64'h0, 1'b1}) begin
      mismatched++;
      $display("FAIL rotc8_by8: lat=%0d/%0d res=%h/%h c=%b/%b z=%b, required lat=1/8 res=0 c=1 z=1",
               lat_f, lat_s, res_f, res_s, car_f, car_s, zer_f);
    end
    run_op(BITS_16, 1'b0, 1'b1, 1'b0, 64'h0001, 8'd10, 1'b0);
    compared++;
    if ({lat_f, lat_s} !== {32'sd3, 32'sd10} || {res_f, car_f} !== {64'h0400, 1'b0} || res_s !== 64'h0400) begin
      mismatched++;
      $display("FAIL rotc16_by10: lat=%0d/%0d res=%h/%h c=%b, required lat=3/10 res=0400 c=0",
               lat_f, lat_s, res_f, res_s, car_f);
    end
  endtask

  task automatic test_fast_step();
    run_op(BITS_64, 1'b0, 1'b0, 1'b0, 64'h1, 8'd63, 1'b0);
    compared++;
    if ({lat_f, lat_s} !== {32'sd14, 32'sd63}) begin
      mismatched++;
      $display("FAIL rot64_latency: got %0d/%0d, required 14/63", lat_f, lat_s);
    end
    compared++;
    if ({res_f, car_f, zer_f, neg_f} !== {64'h8000_0000_0000_0000, 3'b001}
        || {res_s, car_s, zer_s, neg_s} !== {64'h8000_0000_0000_0000, 3'b001}) begin
      mismatched++;
      $display("FAIL rot64_by63: res=%h/%h c=%b n=%b, required res=8000000000000000 c=0 z=0 n=1",
               res_f, res_s, car_f, neg_f);
    end
    run_op(BITS_64, 1'b0, 1'b0, 1'b1, 64'h1, 8'd64, 1'b0);
    compared++;
    if ({lat_f, lat_s} !== {32'sd0, 32'sd0} || {res_f, car_f, zer_f, neg_f} !== {64'h1, 3'b000}) begin
      mismatched++;
      $display("FAIL rot64_k0: lat=%0d/%0d res=%h c=%b, required lat=0/0 res=1 c=0",
               lat_f, lat_s, res_f, car_f);
    end
  endtask

  task automatic test_shift();
    run_op(BITS_16, 1'b1, 1'b0, 1'b0, 64'h8001, 8'd16, 1'b0);
    compared++;
    if ({lat_f, lat_s} !== {32'sd2, 32'sd16} || {res_f, car_f, zer_f, neg_f} !== {64'h0, 3'b110}
        || {res_s, car_s} !== {64'h0, 1'b1}) begin
      mismatched++;
      $display("FAIL shl16_by16: lat=%0d/%0d res=%h c=%b/%b z=%b, required lat=2/16 res=0 c=1 z=1",
               lat_f, lat_s, res_f, car_f, car_s, zer_f);
    end
    run_op(BITS_16, 1'b1, 1'b1, 1'b1, 64'h8001, 8'd17, 1'b0);
    compared++;
    if ({lat_f, lat_s} !== {32'sd3, 32'sd17} || {res_f, car_f, zer_f} !== {64'h0, 2'b01} || car_s !== 1'b0) begin
      mismatched++;
      $display("FAIL shl16_by17: lat=%0d/%0d res=%h c=%b/%b, required lat=3/17 res=0 c=0",
               lat_f, lat_s, res_f, car_f, car_s);
    end
    run_op(BITS_16, 1'b1, 1'b0, 1'b1, 64'h8001, 8'd200, 1'b0);
    compared++;
    if ({lat_f, lat_s} !== {32'sd3, 32'sd17} || {res_f, car_f} !== {64'h0, 1'b0}) begin
      mismatched++;
      $display("FAIL shl16_cap: lat=%0d/%0d res=%h c=%b, required lat=3/17 res=0 c=0",
               lat_f, lat_s, res_f, car_f);
    end
    run_op(BITS_16, 1'b1, 1'b0, 1'b0, 64'h8001, 8'd15, 1'b0);
    compared++;
    if ({lat_f, lat_s} !== {32'sd8, 32'sd15} || {res_f, car_f, zer_f, neg_f} !== {64'h8000, 3'b001}) begin
      mismatched++;
      $display("FAIL shl16_by15: lat=%0d/%0d res=%h c=%b z=%b n=%b, required lat=8/15 res=8000 c=0 z=0 n=1",
               lat_f, lat_s, res_f, car_f, zer_f, neg_f);
    end
    run_op(BITS_8, 1'b1, 1'b0, 1'b1, 64'h81, 8'd0, 1'b0);
    compared++;
    if (lat_f !== 0 || {res_f, car_f, zer_f, neg_f} !== {64'h81, 3'b001}) begin
      mismatched++;
      $display("FAIL shl8_by0: lat=%0d res=%h c=%b n=%b, required lat=0 res=81 c=0 n=1",
               lat_f, res_f, car_f, neg_f);
    end
  endtask

  task automatic test_invalid_size();
    run_op(4'b0011, 1'b0, 1'b1, 1'b1, 64'hFF, 8'd5, 1'b0);
    compared++;
    if ({lat_f, lat_s} !== {32'sd0, 32'sd0} || {res_f, car_f} !== {64'h0, 1'b0}) begin
      mismatched++;
      $display("FAIL invalid_size: lat=%0d/%0d res=%h c=%b, required lat=0/0 res=0 c=0",
               lat_f, lat_s, res_f, car_f);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    size = BITS_8; mode = 1'b0; useCarry = 1'b0; carryIn = 1'b0; a = 64'h81; b = 8'd1; start = 1'b1;
    @(posedge clk); #1;
    a = 64'h40; b = 8'd2;
    @(posedge clk); #1;
    compared++;
    if ({done_f, res_o_f, car_o_f} !== {1'b1, 64'h03, 1'b1}) begin
      mismatched++;
      $display("FAIL b2b_first: done=%b res=%h c=%b, required done=1 res=03 c=1", done_f, res_o_f, car_o_f);
    end
    @(posedge clk); #1;
    compared++;
    if ({done_f, busy_f, done_s, busy_s} !== 4'b0000) begin
      mismatched++;
      $display("FAIL b2b_done_ignores_start: done/busy=%b%b %b%b, required 00 00", done_f, busy_f, done_s, busy_s);
    end
    @(posedge clk); #1;
    start = 1'b0;
    compared++;
    if ({busy_f, done_f, res_o_f} !== {2'b10, 64'h03}) begin
      mismatched++;
      $display("FAIL b2b_accept: busy=%b done=%b res=%h, required busy=1 done=0 res=03", busy_f, done_f, res_o_f);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    compared++;
    if ({done_f, res_o_f, car_o_f} !== {1'b1, 64'h01, 1'b1} || {done_s, res_o_s} !== {1'b1, 64'h01}) begin
      mismatched++;
      $display("FAIL b2b_second: done=%b/%b res=%h/%h c=%b, required done=1 res=01 c=1",
               done_f, done_s, res_o_f, res_o_s, car_o_f);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_abort();
    int stray_done;
    run_op(BITS_64, 1'b0, 1'b0, 1'b0, 64'h1, 8'd63, 1'b1);
    compared++;
    if ({lat_f, lat_s} !== {32'sd14, 32'sd63} || res_f !== 64'h8000_0000_0000_0000
        || res_s !== 64'h8000_0000_0000_0000) begin
      mismatched++;
      $display("FAIL start_while_busy: lat=%0d/%0d res=%h/%h, required lat=14/63 res=8000000000000000",
               lat_f, lat_s, res_f, res_s);
    end
    @(negedge clk);
    size = BITS_8; mode = 1'b0; useCarry = 1'b0; carryIn = 1'b0; a = 64'h81; b = 8'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    #2 rst_n = 1'b0;
    #1;
    compared++;
    if ({busy_f, done_f, res_o_f, car_o_f, zer_o_f, neg_o_f} !== 69'd0
        || {busy_s, done_s, res_o_s, car_o_s, zer_o_s, neg_o_s} !== 69'd0) begin
      mismatched++;
      $display("FAIL async_abort: busy=%b/%b res=%h/%h n=%b, required all 0",
               busy_f, busy_s, res_o_f, res_o_s, neg_o_f);
    end
    @(negedge clk); rst_n = 1'b1;
    stray_done = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (done_f || done_s || busy_f || busy_s) stray_done++;
    end
    compared++;
    if (stray_done !== 0) begin
      mismatched++;
      $display("FAIL abort_no_done: %0d cycles with done/busy after abort, required 0", stray_done);
    end
    run_op(BITS_8, 1'b0, 1'b0, 1'b0, 64'h81, 8'd1, 1'b0);
    compared++;
    if (lat_f !== 1 || {res_f, car_f, zer_f, neg_f} !== {64'h03, 3'b100}) begin
      mismatched++;
      $display("FAIL after_abort: lat=%0d res=%h c=%b, required lat=1 res=03 c=1", lat_f, res_f, car_f);
    end
  endtask

  initial begin
    test_reset();
    test_rotate();
    test_rotate_carry();
    test_fast_step();
    test_shift();
    test_invalid_size();
    test_back_to_back();
    test_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
